// File: rtl/serial_shift_pkg.sv
// Shared types and sizing helpers for serial_shift_scheduler.
// Defining SERIAL_SHIFT_SCHED_PARITY_EN appends an even-parity bit to every frame.
package serial_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int GAP_CNT_W = 4;

`ifdef SERIAL_SHIFT_SCHED_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_bits(input int width);
    return width + PARITY_BITS;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serial_shift_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = (req == 2'b11) ? ~last : req[1];
    grant  = 2'b00;
    if (req != 2'b00) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/serial_shift_scheduler.sv
// Shares one LSB-first serial channel between two requesters with a fixed idle gap.
// Optional even parity bit under SERIAL_SHIFT_SCHED_PARITY_EN.
module serial_shift_scheduler
  import serial_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0_Valid,
  input  logic [WIDTH-1:0] Req0_Data,
  output logic             Req0_Ready,
  input  logic             Req1_Valid,
  input  logic [WIDTH-1:0] Req1_Data,
  output logic             Req1_Ready,
  output logic             Sout,
  output logic             Sout_Valid,
  output logic             Grant_Id,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Dbg_State
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int FB    = frame_bits(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(FB - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sreg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [GAP_CNT_W-1:0] gap_q;
  logic                 ptr_q, granted_q;
  logic                 sout_valid_q, done_q, busy_q, grant_id_q;
  logic                 sout_valid_d, done_d, accept;
  logic [1:0]           grant_oh;
  logic                 winner, arb_last;
  logic [WIDTH-1:0]     arb_data;

`ifdef SERIAL_SHIFT_SCHED_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_POS = CNT_W'(WIDTH - 1);
  logic par_q;
`endif

  // Until the first grant, present "last = 1" so requester 0 takes the first tie.
  assign arb_last = granted_q ? ptr_q : 1'b1;

  rr_arbiter2 u_arb (
    .req    ({Req1_Valid, Req0_Valid}),
    .last   (arb_last),
    .grant  (grant_oh),
    .winner (winner)
  );

  assign arb_data = winner ? Req1_Data : Req0_Data;

  // Handshake: a word moves on any edge where Valid and Ready are both high.
  // Ready is only offered in IDLE, to the arbiter winner, and is held low in reset.
  assign Req0_Ready = Reset && (state_q == ST_IDLE) && grant_oh[0];
  assign Req1_Ready = Reset && (state_q == ST_IDLE) && grant_oh[1];

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant_oh) begin
          accept       = 1'b1;
          sout_valid_d = 1'b1;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end else begin
          sout_valid_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      ptr_q        <= 1'b0;
      granted_q    <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
`ifdef SERIAL_SHIFT_SCHED_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
      busy_q       <= (state_d != ST_IDLE);
      gap_q        <= (state_q == ST_GAP) ? gap_q + GAP_CNT_W'(1) : '0;
      if (accept) begin
        sreg_q     <= arb_data;
        cnt_q      <= '0;
        grant_id_q <= winner;
        ptr_q      <= winner;
        granted_q  <= 1'b1;
`ifdef SERIAL_SHIFT_SCHED_PARITY_EN
        par_q      <= ^arb_data;
`endif
      end else if (state_q == ST_SHIFT) begin
        cnt_q <= cnt_q + CNT_W'(1);
`ifdef SERIAL_SHIFT_SCHED_PARITY_EN
        // The parity bit is dropped into bit 0 once the last data bit has been shown.
        if (cnt_q == PAR_POS) sreg_q <= WIDTH'(par_q);
        else                  sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
`else
        sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
`endif
      end
    end
  end

  // Bit 0 of the shift register is the line; zero-fill leaves it low in GAP and IDLE.
  assign Sout       = sreg_q[0];
  assign Sout_Valid = sout_valid_q;
  assign Grant_Id   = grant_id_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Dbg_State  = state_q;

endmodule

// File: tb/tb_serial_shift_scheduler.sv
// Bench for serial_shift_scheduler: vector table, corner sequences and random traffic
// checked against a cycle-arithmetic reference model and a word scoreboard.
module tb_serial_shift_scheduler;

  localparam int W = 8;
  localparam int G = 1;
`ifdef SERIAL_SHIFT_SCHED_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB     = W + PB;
  localparam int PERIOD = FB + G + 1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk, rst_n;
  logic         v0, v1, r0, r1;
  logic [W-1:0] d0, d1;
  logic         sout, sv, gid, busy, done;
  logic [1:0]   dbg;

  logic         g3_v0, g3_v1, g3_r0, g3_r1;
  logic [W-1:0] g3_d0, g3_d1;
  logic         g3_sout, g3_sv, g3_gid, g3_busy, g3_done;
  logic [1:0]   g3_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  serial_shift_scheduler #(.WIDTH(W), .GAP(G)) dut (
    .Clock(clk), .Reset(rst_n),
    .Req0_Valid(v0), .Req0_Data(d0), .Req0_Ready(r0),
    .Req1_Valid(v1), .Req1_Data(d1), .Req1_Ready(r1),
    .Sout(sout), .Sout_Valid(sv), .Grant_Id(gid), .Busy(busy), .Done(done),
    .Dbg_State(dbg)
  );

  serial_shift_scheduler #(.WIDTH(W), .GAP(3)) dut3 (
    .Clock(clk), .Reset(rst_n),
    .Req0_Valid(g3_v0), .Req0_Data(g3_d0), .Req0_Ready(g3_r0),
    .Req1_Valid(g3_v1), .Req1_Data(g3_d1), .Req1_Ready(g3_r1),
    .Sout(g3_sout), .Sout_Valid(g3_sv), .Grant_Id(g3_gid), .Busy(g3_busy), .Done(g3_done),
    .Dbg_State(g3_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting on DUT (t=%0t)", name, $time);
  endtask

  logic [W:0] exp_q[$];
  int         rise_q[$];
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         have_frame = 0, any_g = 0, last_g = 0, exp_gid = 0, prev_sv = 0;
  logic [W:0] col = '0;
  int         col_n = 0;

  // A frame accepted in cycle a owns bits a+1..a+FB, Done at a+FB+1, and the
  // channel is free again from a+PERIOD on.
  always @(negedge clk) begin
    bit idle, w, er0, er1, esv, ebusy, edone;
    logic [W:0] word;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {r0, r1, sout, sv, gid, busy, done}, 64'd0);
      have_frame = 0; any_g = 0; last_g = 0; exp_gid = 0; prev_sv = 0;
      col = '0; col_n = 0;
      exp_q.delete();
    end else begin
      idle = !have_frame || (cyc >= acc_cyc + PERIOD);
      w = 0; er0 = 0; er1 = 0;
      if (idle && (v0 || v1)) begin
        w   = (v0 && v1) ? (any_g ? ~last_g : 1'b0) : v1;
        er0 = ~w;
        er1 = w;
      end
      chk("ready", {r0, r1}, {er0, er1});
      esv   = have_frame && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + FB);
      ebusy = have_frame && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + FB + G);
      edone = have_frame && (cyc == acc_cyc + FB + 1);
      chk("sv_busy_done_gid", {sv, busy, done, gid}, {esv, ebusy, edone, exp_gid});
      if (sv && !prev_sv) rise_q.push_back(cyc);
      if (sv) begin
        if (col_n <= W) col[col_n] = sout;
        col_n++;
      end else begin
        chk("sout_quiet", sout, 1'b0);
        if (col_n > 0) begin
          if (exp_q.size() == 0) begin
            timeout_fail("frame_unexpected");
          end else begin
            word = exp_q.pop_front();
            chk("frame_len", col_n, FB);
            chk("frame_word", col, word);
          end
          col = '0;
          col_n = 0;
        end
      end
      prev_sv = sv;
      if (er0 || er1) begin
        have_frame = 1; acc_cyc = cyc; last_g = w; any_g = 1; exp_gid = w;
        word = '0;
        word[W-1:0] = w ? d1 : d0;
        word[W] = (PB == 1) ? ^word[W-1:0] : 1'b0;
        exp_q.push_back(word);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag, output bit who);
    int n;
    who = 0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (r0 || r1) break;
    end
    if (n == 200) timeout_fail(tag);
    who = r1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == 200) timeout_fail(tag);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         v0;
    bit         v1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    bit         gid;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    bit who;
    int t0, lows, dn, n;
    rst_n = 0; v0 = 0; v1 = 0; d0 = '0; d1 = '0;
    g3_v0 = 0; g3_v1 = 0; g3_d0 = '0; g3_d1 = '0;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h01, 8'h80, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'h7E, 8'h81, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h07, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      v0 = vecs[i].v0; v1 = vecs[i].v1; d0 = vecs[i].d0; d1 = vecs[i].d1;
      wait_ready("vec_ready", who);
      v0 = 0; v1 = 0;
      chk("vec_grant", who, vecs[i].gid);
      chk("vec_gid_out", gid, vecs[i].gid);
      wait_idle("vec_idle");
    end

    // Both requesters held: alternate grants, one frame every PERIOD cycles.
    rise_q.delete();
    v0 = 1; v1 = 1; d0 = 8'h01; d1 = 8'h80;
    for (int i = 0; i < 4; i++) begin
      wait_ready("tie_ready", who);
      chk("tie_grant", who, i % 2);
    end
    v0 = 0; v1 = 0;
    wait_idle("tie_idle");
    chk("tie_frames", rise_q.size(), 4);
    for (int i = 1; i < rise_q.size(); i++)
      chk("tie_spacing", rise_q[i] - rise_q[i-1], PERIOD);

    // Req1 raised mid-frame must wait for the first IDLE cycle.
    v0 = 1; d0 = 8'h3C;
    wait_ready("ign_ready0", who);
    v0 = 0;
    t0 = cyc;
    v1 = 1; d1 = 8'h5A;
    wait_ready("ign_ready1", who);
    chk("ign_who", who, 1'b1);
    chk("ign_latency", cyc - t0, PERIOD);
    v1 = 0;
    wait_idle("ign_idle");

    // Reset during the 4th bit aborts the frame.
    v0 = 1; d0 = 8'hF0;
    wait_ready("mrst_ready", who);
    v0 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_active", {sv, busy}, 2'b11);
    rst_n = 0;
    #1;
    chk("mrst_outputs", {r0, r1, sout, sv, gid, busy, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    v1 = 1; d1 = 8'h96;
    wait_ready("mrst_req1", who);
    v1 = 0;
    chk("mrst_who", who, 1'b1);
    chk("mrst_gid", gid, 1'b1);
    wait_idle("mrst_idle");

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      bit a0, a1;
      @(negedge clk);
      a0 = r0; a1 = r1;
      @(posedge clk);
      #1;
      if (a0) v0 = 0;
      else if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1; d0 = W'($urandom); end
      if (a1) v1 = 0;
      else if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1; d1 = W'($urandom); end
    end
    // Let any pending request be taken before dropping Valid.
    while (v0 || v1) begin
      wait_ready("rand_drain", who);
      if (who) v1 = 0; else v0 = 0;
    end
    wait_idle("rand_idle");
    chk("scoreboard_drained", exp_q.size(), 0);

    // GAP=3 instance: back-to-back frames separated by 3 GAP + 1 IDLE cycles.
    g3_v0 = 1; g3_d0 = 8'hC3;
    for (n = 0; n < 100 && !g3_sv; n++) @(negedge clk);
    if (n == 100) timeout_fail("gap3_first");
    for (n = 0; n < 100 && g3_sv; n++) @(negedge clk);
    if (n == 100) timeout_fail("gap3_end");
    lows = 0; dn = 0;
    for (n = 0; n < 100 && !g3_sv; n++) begin
      lows++;
      dn += int'(g3_done);
      @(negedge clk);
    end
    if (n == 100) timeout_fail("gap3_next");
    chk("gap3_idle_cycles", lows, 4);
    chk("gap3_done_pulses", dn, 1);
    @(posedge clk);
    #1 g3_v0 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_shift_scheduler.md
# serial_shift_scheduler

Controller that shares one serial shift-out channel between two parallel-word requesters. Arbitrates round-robin, accepts a WIDTH-bit word over a valid/ready handshake, and serialises it LSB-first on `Sout` with a qualifying strobe. Enforces a programmable idle gap between frames. Sits between parallel producers and a single serial line, replacing ad-hoc direct drive of a SISO shift register.

## Interface
- `WIDTH`, 8: data bits per frame; legal range 2..32.
- `GAP`, 1: idle cycles after each frame; legal range 1..15.

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Req0_Valid`  in  1  requester 0 has a word.
- `Req0_Data`  in  WIDTH  requester 0 word.
- `Req0_Ready`  out  1  requester 0 word accepted this cycle.
- `Req1_Valid`  in  1  requester 1 has a word.
- `Req1_Data`  in  WIDTH  requester 1 word.
- `Req1_Ready`  out  1  requester 1 word accepted this cycle.
- `Sout`  out  1  serial data.
- `Sout_Valid`  out  1  `Sout` carries a frame bit.
- `Grant_Id`  out  1  requester owning the current or last frame.
- `Busy`  out  1  high in any state other than IDLE.
- `Done`  out  1  one-cycle pulse after a frame's last bit.

## Operation
- The controller has 3 states: IDLE, SHIFT and GAP. On reset the state is IDLE.
- Reset value of every output is 0. The round-robin pointer also resets to 0, so requester 0 wins the first tie.
- **IDLE:**
  - The winner is computed combinationally from the Valid signals and the pointer. On a tie, the requester not granted last wins. A lone request wins outright.
  - The winner's Ready is driven high combinationally in the same cycle. A Ready is never high outside IDLE, and never high for both requesters at once.
  - On the Valid&&Ready edge:
    - the word is captured into the internal WIDTH-bit shift register;
    - `Grant_Id` is set to the winner;
    - the pointer is updated to the winner;
    - the bit counter is cleared;
    - the state moves to SHIFT.
  - With no Valid, the controller stays in IDLE.
- **SHIFT:**
  - `Sout` = shift register bit 0, and `Sout_Valid` = 1.
  - On each edge, the register shifts right (0 filled into the MSB) and the counter increments.
  - After WIDTH bits (FRAME_BITS with parity), the state moves to GAP.
- **GAP:**
  - `Sout` = 0 and `Sout_Valid` = 0.
  - `Done` = 1 in the first GAP cycle only.
  - The state stays in GAP for exactly GAP cycles, then returns to IDLE.
- **Inputs outside IDLE:** Valid and Data from either requester are ignored. Requesters must hold Valid and Data stable until Ready.
- **Counter width:** the counter is $clog2(WIDTH+2) bits wide and never wraps within a frame.
- **Reset mid-frame:** the frame is aborted immediately, with no `Done` pulse. The partial word is discarded.

## Timing
- **Handshake:** accept edge t. The first bit is on `Sout` in cycle t+1. The last bit is in cycle t+FRAME_BITS.
- **Done:** `Done` is high in cycle t+FRAME_BITS+1.
- **Earliest next accept:** cycle t+FRAME_BITS+GAP+1, the first IDLE cycle. Ready can be high in that cycle.
- **Throughput:** the frame period is FRAME_BITS+GAP+1 cycles under continuous demand.
- **Output drive:** `Sout`, `Sout_Valid`, `Busy`, `Done` and `Grant_Id` are registered. Only the Ready outputs are combinational, decoded from state plus Valid.

## Configuration
- **`SERIAL_SHIFT_SCHED_PARITY_EN` defined:** one even-parity bit (XOR of the captured word) is appended after the data bits.
  - FRAME_BITS = WIDTH+1.
  - `Sout_Valid` covers the parity bit.
  - The parity bit is computed at capture and stored in an extra register stage.
- **Undefined:** FRAME_BITS = WIDTH. No parity logic is instantiated.

## Structure
- **Package `serial_shift_pkg`:**
  - state enum (IDLE, SHIFT, GAP);
  - FRAME_BITS derivation helper;
  - localparam for counter width.
- **Sub-module `rr_arbiter2`:**
  - inputs: two request bits and the last-grant pointer;
  - outputs: a one-hot grant and the winner index;
  - purely combinational.
- **Top level:** holds the FSM, shift register, bit counter, gap counter and pointer register.

## Test plan
- **Single frame:** WIDTH=8, GAP=1, reset released, Req0 sends 8'hA5.
  - Required: Req0_Ready high 1 cycle; `Sout` shows 1,0,1,0,0,1,0,1 over 8 cycles with `Sout_Valid`.
  - Required: `Done` high in the next cycle; `Grant_Id`=0.
- **Round-robin tie:** both Valid held with 8'h01 and 8'h80.
  - Required: grants are 0,1,0,1.
  - Required: each frame starts exactly 10 cycles apart (8+1+1).
- **Parity:** with `SERIAL_SHIFT_SCHED_PARITY_EN`, Req1 sends 8'h07.
  - Required: 9 valid bits, the last bit = 1.
- **Mid-frame reset:** Reset low during the 4th bit.
  - Required: all outputs 0 immediately, no `Done`.
  - Required: after release, Req1 alone is granted first, with `Grant_Id`=1.
- **Ignored input:** Req1_Valid asserted during SHIFT.
  - Required: Req1_Ready stays 0 until IDLE.
  - Required: Req1 is then accepted in the first IDLE cycle.
- **GAP=3:** back-to-back Req0 frames.
  - Required: `Sout_Valid` low for exactly 4 cycles between frames (3 GAP + 1 IDLE).
